// File: rtl/pri_enc_scan.sv
// pri_enc_scan
//   Sequential priority scanner. Accepts a WIDTH-bit request vector through a
//   valid/ready handshake, then emits the index of every set bit, one beat per
//   handshake, in priority order. The final beat of each vector carries
//   out_last. An all-zero vector produces a single out_none beat.
//
// Parameters
//   WIDTH      request vector width (>= 2)
//   IDXW       index width, derived from WIDTH (do not override)
//   MSB_FIRST  1: highest set index first, 0: lowest set index first
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_vec is presented
//   in_ready   block is idle and can take a vector
//   in_vec     request vector
//   out_valid  out_idx/out_none/out_last are valid
//   out_ready  consumer takes the current beat
//   out_idx    index of the current set bit
//   out_none   current beat stands for an all-zero vector
//   out_last   final beat of the current vector
//   out_cnt    popcount of the vector being scanned (held until next accept)
module pri_enc_scan #(
    parameter int WIDTH     = 8,
    parameter int IDXW      = $clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_none,
    output logic             out_last,
    output logic [IDXW:0]    out_cnt
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] pend, pend_nx;
    logic             zero_f, zero_nx;
    logic [IDXW:0]    cnt_r, cnt_nx;

    logic [IDXW-1:0]  idx;   // priority-encoded index of pend
    logic [WIDTH-1:0] sel;   // one-hot mask of that same bit
    logic [WIDTH-1:0] rest;  // pend with the selected bit removed

    function automatic logic [IDXW:0] popcount(input logic [WIDTH-1:0] v);
        logic [IDXW:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + (IDXW+1)'(v[i]);
        end
        return c;
    endfunction

    // Priority select: the last match in loop order wins, so the loop runs
    // towards the winning end of the vector.
    always_comb begin
        idx = '0;
        sel = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (pend[i]) begin
                    idx    = IDXW'(i);
                    sel    = '0;
                    sel[i] = 1'b1;
                end
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (pend[i]) begin
                    idx    = IDXW'(i);
                    sel    = '0;
                    sel[i] = 1'b1;
                end
            end
        end
    end

    // Nothing left after removing the selected bit means this beat is last.
    assign rest = pend & ~sel;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pend   <= '0;
            zero_f <= 1'b0;
            cnt_r  <= '0;
        end else begin
            state  <= state_nx;
            pend   <= pend_nx;
            zero_f <= zero_nx;
            cnt_r  <= cnt_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        pend_nx  = pend;
        zero_nx  = zero_f;
        cnt_nx   = cnt_r;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    pend_nx  = in_vec;
                    zero_nx  = (in_vec == '0);
                    cnt_nx   = popcount(in_vec);
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    if (zero_f) begin
                        zero_nx  = 1'b0;
                        state_nx = IDLE;
                    end else begin
                        pend_nx = rest;
                        if (rest == '0) begin
                            state_nx = IDLE;
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decode from registers only; in_* never reaches out_* directly.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_none  = 1'b0;
        out_last  = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            SCAN: begin
                out_valid = 1'b1;
                out_none  = zero_f;
                out_idx   = zero_f ? '0 : idx;
                out_last  = zero_f || (rest == '0);
            end
            default: ;
        endcase
    end

    assign out_cnt = cnt_r;

endmodule
